// File: rtl/mem_access_arbiter.sv
// ----------------------------------------------------------------------------
// mem_access_arbiter
//
// Two-master front end for the word-addressed block-RAM. An instruction-fetch
// port (read-only) and a data port (load/store) share the memory's single
// write channel and read channel. The memory side uses a level valid/ready
// handshake: valid is raised at grant, held until ready, then dropped, and a
// one-cycle RELEASE gap follows every completed access. Read data is returned
// to the granted master only, each master gets a one-cycle done pulse, and
// sticky error conditions (misaligned address, memory range error, handshake
// timeout) freeze the arbiter until reset.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   if_req/if_addr        fetch request (level, held until if_done) + byte addr
//   if_rdata/if_done      fetch data (held until next fetch) + completion pulse
//   d_req/d_we/d_addr     data request (level), store select, byte address
//   d_wdata               store data
//   d_rdata/d_done        load data (held until next load) + completion pulse
//   mem_in_addr/_data     memory write address/data
//   mem_in_valid/_ready   memory write handshake
//   mem_out_addr          memory read address
//   mem_out_valid/_ready  memory read handshake
//   mem_out_data          memory read data, valid while mem_out_ready
//   mem_addr_error        memory sticky range error (rising edge recorded)
//   err/err_cause         sticky error flag; 01 misaligned, 10 range, 11 timeout
//
// States
//   state   | meaning
//   IDLE    | waiting for a request; arbitrates and launches a transaction
//   WRITE   | mem_in_valid high, waiting for mem_in_ready
//   READ    | mem_out_valid high, waiting for mem_out_ready
//   RELEASE | both valids low for one cycle; done pulse visible
//   HALT    | error seen; no further grants until reset
// ----------------------------------------------------------------------------
module mem_access_arbiter #(
    parameter int ALIGN_CHECK    = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] mem_in_addr,
    output logic [31:0] mem_in_data,
    output logic        mem_in_valid,
    input  logic        mem_in_ready,
    output logic [31:0] mem_out_addr,
    output logic        mem_out_valid,
    input  logic [31:0] mem_out_data,
    input  logic        mem_out_ready,
    input  logic        mem_addr_error,
    output logic        err,
    output logic [1:0]  err_cause
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RELEASE,
        ST_HALT
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    state_t      state, state_n;

    // last_grant_d: 1 when the data port won the most recent grant.
    // cur_is_d:     1 when the transaction in flight belongs to the data port.
    logic        last_grant_d, last_grant_d_n;
    logic        cur_is_d, cur_is_d_n;
    logic [7:0]  timer, timer_n;
    logic        aerr_q;

    logic [31:0] mem_in_addr_n, mem_in_data_n, mem_out_addr_n;
    logic        mem_in_valid_n, mem_out_valid_n;
    logic [31:0] if_rdata_n, d_rdata_n;
    logic        if_done_n, d_done_n;
    logic        err_n;
    logic [1:0]  err_cause_n;

    // ------------------------------------------------------------------
    // Arbitration terms, only meaningful in IDLE
    // ------------------------------------------------------------------
    logic        grant_any;
    logic        grant_d;
    logic [31:0] g_addr;
    logic        g_store;
    logic        misaligned;
    logic [8:0]  timer_inc;
    logic        timeout_hit;
    logic        aerr_rise;

    always_comb begin
        grant_any = if_req | d_req;
        // With both requesting, the port that did not win last time goes.
        grant_d   = d_req & (~if_req | ~last_grant_d);
        g_addr    = grant_d ? d_addr : if_addr;
        g_store   = grant_d & d_we;
        misaligned = (ALIGN_CHECK != 0) && (g_addr[1:0] != 2'b00);
        timer_inc   = {1'b0, timer} + 9'd1;
        // Valid has been high for timer+1 cycles at the end of this one.
        timeout_hit = (timer_inc == 9'(TIMEOUT_CYCLES));
        aerr_rise   = mem_addr_error & ~aerr_q;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            last_grant_d  <= 1'b0;
            cur_is_d      <= 1'b0;
            timer         <= 8'd0;
            aerr_q        <= 1'b0;
            mem_in_addr   <= 32'd0;
            mem_in_data   <= 32'd0;
            mem_in_valid  <= 1'b0;
            mem_out_addr  <= 32'd0;
            mem_out_valid <= 1'b0;
            if_rdata      <= 32'd0;
            d_rdata       <= 32'd0;
            if_done       <= 1'b0;
            d_done        <= 1'b0;
            err           <= 1'b0;
            err_cause     <= CAUSE_NONE;
        end else begin
            state         <= state_n;
            last_grant_d  <= last_grant_d_n;
            cur_is_d      <= cur_is_d_n;
            timer         <= timer_n;
            aerr_q        <= mem_addr_error;
            mem_in_addr   <= mem_in_addr_n;
            mem_in_data   <= mem_in_data_n;
            mem_in_valid  <= mem_in_valid_n;
            mem_out_addr  <= mem_out_addr_n;
            mem_out_valid <= mem_out_valid_n;
            if_rdata      <= if_rdata_n;
            d_rdata       <= d_rdata_n;
            if_done       <= if_done_n;
            d_done        <= d_done_n;
            err           <= err_n;
            err_cause     <= err_cause_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (err) begin
                    state_n = ST_HALT;
                end else if (grant_any) begin
                    if (misaligned)   state_n = ST_HALT;
                    else if (g_store) state_n = ST_WRITE;
                    else              state_n = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_in_ready)     state_n = ST_RELEASE;
                else if (timeout_hit) state_n = ST_HALT;
            end
            ST_READ: begin
                if (mem_out_ready)    state_n = ST_RELEASE;
                else if (timeout_hit) state_n = ST_HALT;
            end
            ST_RELEASE: state_n = ST_IDLE;
            ST_HALT:    state_n = ST_HALT;
            default:    state_n = ST_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Next values of the registered outputs
    // ------------------------------------------------------------------
    logic       fault;
    logic [1:0] fault_cause;

    always_comb begin
        last_grant_d_n  = last_grant_d;
        cur_is_d_n      = cur_is_d;
        timer_n         = timer;
        mem_in_addr_n   = mem_in_addr;
        mem_in_data_n   = mem_in_data;
        mem_in_valid_n  = mem_in_valid;
        mem_out_addr_n  = mem_out_addr;
        mem_out_valid_n = mem_out_valid;
        if_rdata_n      = if_rdata;
        d_rdata_n       = d_rdata;
        if_done_n       = 1'b0;
        d_done_n        = 1'b0;
        err_n           = err;
        err_cause_n     = err_cause;
        fault           = 1'b0;
        fault_cause     = CAUSE_NONE;

        case (state)
            ST_IDLE: begin
                if (!err && grant_any) begin
                    last_grant_d_n = grant_d;
                    cur_is_d_n     = grant_d;
                    timer_n        = 8'd0;
                    if (g_store) begin
                        mem_in_addr_n = g_addr;
                        mem_in_data_n = d_wdata;
                    end else begin
                        mem_out_addr_n = g_addr;
                    end
                    if (misaligned) begin
                        fault       = 1'b1;
                        fault_cause = CAUSE_MISALIGN;
                    end else if (g_store) begin
                        mem_in_valid_n = 1'b1;
                    end else begin
                        mem_out_valid_n = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_in_ready) begin
                    mem_in_valid_n = 1'b0;
                    d_done_n       = 1'b1;
                end else if (timeout_hit) begin
                    mem_in_valid_n = 1'b0;
                    fault          = 1'b1;
                    fault_cause    = CAUSE_TIMEOUT;
                end else begin
                    timer_n = timer_inc[7:0];
                end
            end
            ST_READ: begin
                if (mem_out_ready) begin
                    mem_out_valid_n = 1'b0;
                    if (cur_is_d) begin
                        d_rdata_n = mem_out_data;
                        d_done_n  = 1'b1;
                    end else begin
                        if_rdata_n = mem_out_data;
                        if_done_n  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    mem_out_valid_n = 1'b0;
                    fault           = 1'b1;
                    fault_cause     = CAUSE_TIMEOUT;
                end else begin
                    timer_n = timer_inc[7:0];
                end
            end
            default: begin
                mem_in_valid_n  = 1'b0;
                mem_out_valid_n = 1'b0;
            end
        endcase

        // First recorded cause is kept; an arbiter fault on the same edge as
        // a range-error rise takes precedence over it.
        if (fault) begin
            err_n = 1'b1;
            if (err_cause_n == CAUSE_NONE) err_cause_n = fault_cause;
        end
        if (aerr_rise) begin
            err_n = 1'b1;
            if (err_cause_n == CAUSE_NONE) err_cause_n = CAUSE_RANGE;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

    localparam int TO = 15;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [31:0] mem_in_addr;
    logic [31:0] mem_in_data;
    logic        mem_in_valid;
    logic        mem_in_ready;
    logic [31:0] mem_out_addr;
    logic        mem_out_valid;
    logic [31:0] mem_out_data;
    logic        mem_out_ready;
    logic        mem_addr_error;
    logic        err;
    logic [1:0]  err_cause;

    mem_access_arbiter #(.ALIGN_CHECK(1), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_in_addr(mem_in_addr), .mem_in_data(mem_in_data),
        .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready),
        .mem_out_addr(mem_out_addr), .mem_out_valid(mem_out_valid),
        .mem_out_data(mem_out_data), .mem_out_ready(mem_out_ready),
        .mem_addr_error(mem_addr_error), .err(err), .err_cause(err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model: write ready after 2 valid cycles, read after 3
    logic [31:0] mem_arr [0:63];
    int  wcnt = 0, rcnt = 0;
    bit  rd_stall = 1'b0;

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
        mem_in_ready = 1'b0; mem_out_ready = 1'b0; mem_out_data = 32'h0;
        forever begin
            @(negedge clk);
            wcnt = mem_in_valid ? wcnt + 1 : 0;
            rcnt = mem_out_valid ? rcnt + 1 : 0;
            mem_in_ready  = (wcnt >= 2);
            mem_out_ready = !rd_stall && (rcnt >= 3);
            mem_out_data  = mem_out_ready ? mem_arr[mem_out_addr[7:2]] : 32'h0;
        end
    end

    initial forever begin
        @(posedge clk);
        if (reset && mem_in_valid && mem_in_ready) mem_arr[mem_in_addr[7:2]] = mem_in_data;
    end

    // ---------------- transaction-level reference model
    bit          m_busy, m_rel, m_halt, m_store, m_port_d, m_last_d, m_err, m_prev_aerr;
    bit          m_if_done, m_d_done;
    logic [1:0]  m_cause;
    int          m_age;
    logic [31:0] m_if_rdata, m_d_rdata, m_in_addr, m_in_data, m_out_addr;

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            m_busy = 0; m_rel = 0; m_halt = 0; m_store = 0; m_port_d = 0; m_last_d = 0;
            m_err = 0; m_prev_aerr = 0; m_if_done = 0; m_d_done = 0; m_cause = 2'd0;
            m_age = 0; m_if_rdata = 0; m_d_rdata = 0;
        end else begin
            bit fault;
            logic [1:0] fcause;
            bit pick_d;
            logic [31:0] a;
            bit hs;
            fault = 0; fcause = 2'd0;
            m_if_done = 0; m_d_done = 0;
            if (m_halt) begin
            end else if (m_rel) begin
                m_rel = 0;
            end else if (m_busy) begin
                hs = m_store ? mem_in_ready : mem_out_ready;
                if (hs) begin
                    m_busy = 0; m_rel = 1;
                    if (!m_store) begin
                        if (m_port_d) m_d_rdata = mem_out_data;
                        else          m_if_rdata = mem_out_data;
                    end
                    if (m_port_d) m_d_done = 1; else m_if_done = 1;
                end else begin
                    m_age++;
                    if (m_age == TO) begin
                        m_busy = 0; m_halt = 1; fault = 1; fcause = 2'd3;
                    end
                end
            end else if (m_err) begin
                m_halt = 1;
            end else if (if_req || d_req) begin
                pick_d = (if_req && d_req) ? !m_last_d : d_req;
                m_last_d = pick_d;
                m_port_d = pick_d;
                m_store = pick_d && d_we;
                a = pick_d ? d_addr : if_addr;
                if (a[1:0] != 2'b00) begin
                    m_halt = 1; fault = 1; fcause = 2'd1;
                end else begin
                    m_busy = 1; m_age = 0;
                    if (m_store) begin m_in_addr = a; m_in_data = d_wdata; end
                    else m_out_addr = a;
                end
            end
            if (fault) begin m_err = 1; if (m_cause == 0) m_cause = fcause; end
            if (mem_addr_error && !m_prev_aerr) begin
                m_err = 1; if (m_cause == 0) m_cause = 2'd2;
            end
            m_prev_aerr = mem_addr_error;
        end
    end

    // ---------------- per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            check("err", 32'(err), 32'(m_err));
            check("err_cause", 32'(err_cause), 32'(m_cause));
            check("if_done", 32'(if_done), 32'(m_if_done));
            check("d_done", 32'(d_done), 32'(m_d_done));
            check("mem_in_valid", 32'(mem_in_valid), 32'(m_busy && m_store));
            check("mem_out_valid", 32'(mem_out_valid), 32'(m_busy && !m_store));
            check("if_rdata", if_rdata, m_if_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
            if (m_busy && m_store) begin
                check("mem_in_addr", mem_in_addr, m_in_addr);
                check("mem_in_data", mem_in_data, m_in_data);
            end
            if (m_busy && !m_store) check("mem_out_addr", mem_out_addr, m_out_addr);
        end
    end

    // ---------------- stimulus helpers
    int wv_cnt, rv_cnt, dd_cnt, fd_cnt;
    int order [0:3];
    int n_order;

    task automatic tick();
        @(negedge clk);
        if (mem_in_valid)  wv_cnt++;
        if (mem_out_valid) rv_cnt++;
        if (d_done)  begin dd_cnt++; if (n_order < 4) begin order[n_order] = 1; n_order++; end end
        if (if_done) begin fd_cnt++; if (n_order < 4) begin order[n_order] = 2; n_order++; end end
    endtask

    task automatic clear_counts();
        wv_cnt = 0; rv_cnt = 0; dd_cnt = 0; fd_cnt = 0; n_order = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_addr_error = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        clear_counts();
    endtask

    task automatic run_req(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat);
        if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else begin if_req = 1'b1; if_addr = addr; end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((is_d && d_done) || (!is_d && if_done)) begin lat = i; break; end
        end
        d_req = 1'b0; if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; mem_addr_error = 1'b0;
        clear_counts();
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b1;
        tick();

        check("rst_err", 32'(err), 32'd0);
        check("rst_cause", 32'(err_cause), 32'd0);
        check("rst_in_valid", 32'(mem_in_valid), 32'd0);
        check("rst_out_valid", 32'(mem_out_valid), 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);

        // single store
        clear_counts();
        run_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, lat);
        check("store_latency", 32'(lat), 32'd3);
        check("store_wvalid_cycles", 32'(wv_cnt), 32'd2);
        check("store_done_count", 32'(dd_cnt), 32'd1);
        check("store_mem_word", mem_arr[4], 32'hDEADBEEF);
        tick();

        // load back
        clear_counts();
        run_req(1'b1, 1'b0, 32'h10, 32'h0, lat);
        check("load_latency", 32'(lat), 32'd4);
        check("load_rdata", d_rdata, 32'hDEADBEEF);
        check("load_if_done", 32'(fd_cnt), 32'd0);
        tick();

        // fetch, data port rdata untouched
        mem_arr[8] = 32'h12345678;
        clear_counts();
        run_req(1'b0, 1'b0, 32'h20, 32'h0, lat);
        check("fetch_latency", 32'(lat), 32'd4);
        check("fetch_rdata", if_rdata, 32'h12345678);
        check("fetch_keeps_d_rdata", d_rdata, 32'hDEADBEEF);
        tick();

        // round-robin with both requests held from reset
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h20;
        for (int i = 0; i < 80 && n_order < 4; i++) tick();
        if_req = 1'b0; d_req = 1'b0;
        check("rr_grant0_D", 32'(order[0]), 32'd1);
        check("rr_grant1_F", 32'(order[1]), 32'd2);
        check("rr_grant2_D", 32'(order[2]), 32'd1);
        check("rr_grant3_F", 32'(order[3]), 32'd2);
        tick(); tick();

        // misaligned data access
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h13;
        repeat (6) tick();
        check("mis_err", 32'(err), 32'd1);
        check("mis_cause", 32'(err_cause), 32'd1);
        check("mis_no_valid", 32'(wv_cnt + rv_cnt), 32'd0);
        check("mis_no_done", 32'(dd_cnt), 32'd0);
        d_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h20;
        repeat (10) tick();
        if_req = 1'b0;
        check("halt_no_valid", 32'(wv_cnt + rv_cnt), 32'd0);
        check("halt_no_done", 32'(fd_cnt + dd_cnt), 32'd0);
        check("halt_cause_kept", 32'(err_cause), 32'd1);

        // read timeout
        do_reset();
        rd_stall = 1'b1;
        if_req = 1'b1; if_addr = 32'h20;
        repeat (30) tick();
        if_req = 1'b0;
        check("to_valid_cycles", 32'(rv_cnt), 32'(TO));
        check("to_cause", 32'(err_cause), 32'd3);
        check("to_err", 32'(err), 32'd1);
        check("to_no_done", 32'(fd_cnt), 32'd0);
        rd_stall = 1'b0;

        // memory range error during a read
        do_reset();
        if_req = 1'b1; if_addr = 32'h20;
        tick(); tick();
        mem_addr_error = 1'b1;
        tick();
        mem_addr_error = 1'b0;
        for (int i = 0; i < 10 && fd_cnt == 0; i++) tick();
        check("aerr_done", 32'(fd_cnt), 32'd1);
        check("aerr_rdata", if_rdata, 32'h12345678);
        check("aerr_cause", 32'(err_cause), 32'd2);
        repeat (10) tick();
        if_req = 1'b0;
        check("aerr_no_more_valid", 32'(rv_cnt), 32'd3);
        check("aerr_no_more_done", 32'(fd_cnt), 32'd1);

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
